// File: rtl/segre_mem_arbiter.sv
// Two-port line-miss arbiter onto one shared memory port: optional writeback then fill, atomic per grant.
// Build option: define SEGRE_MEM_ARB_DPRIO_EN for fixed dcache priority instead of round-robin.
module segre_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int NPORTS     = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rsn_i,
  input  logic [NPORTS-1:0]                       req_i,
  input  logic [NPORTS-1:0]                       wb_i,
  input  logic [NPORTS-1:0][ADDR_W-1:0]           wb_addr_i,
  input  logic [NPORTS-1:0][LINE_BYTES*8-1:0]     wb_line_i,
  input  logic [NPORTS-1:0][ADDR_W-1:0]           fill_addr_i,
  output logic [NPORTS-1:0]                       grant_o,
  output logic [NPORTS-1:0]                       done_o,
  output logic [LINE_BYTES*8-1:0]                 line_o,
  output logic                                    mem_req_o,
  output logic                                    mem_we_o,
  output logic [ADDR_W-1:0]                       mem_addr_o,
  output logic [LINE_BYTES*8-1:0]                 mem_wdata_o,
  input  logic                                    mem_ack_i,
  input  logic [LINE_BYTES*8-1:0]                 mem_rdata_i
);

  localparam int LW  = LINE_BYTES * 8;
  localparam int OFF = $clog2(LINE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

  typedef enum logic [2:0] {IDLE, GRANT, WB, FILL, RESPOND} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [NPORTS-1:0]   done_q, done_d;
  logic [LW-1:0]       line_q, line_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LW-1:0]       mem_wdata_q, mem_wdata_d;
  logic                arb_win;

`ifdef SEGRE_MEM_ARB_DPRIO_EN
  assign arb_win = req_i[1];
`else
  logic last_q, last_d;
  // On a conflict the port that did not win last time gets memory.
  assign arb_win = (&req_i) ? ~last_q : req_i[1];
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    fill_addr_d = fill_addr_q;
    grant_d     = grant_q;
    done_d      = '0;
    line_d      = line_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifndef SEGRE_MEM_ARB_DPRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          win_d            = arb_win;
          grant_d          = '0;
          grant_d[arb_win] = 1'b1;
          state_d          = GRANT;
`ifndef SEGRE_MEM_ARB_DPRIO_EN
          last_d           = arb_win;
`endif
        end
      end
      GRANT: begin
        // The first beat is set up here so mem_req_o comes straight from a flop.
        fill_addr_d = fill_addr_i[win_q] & ALIGN_MASK;
        mem_wdata_d = wb_line_i[win_q];
        mem_req_d   = 1'b1;
        if (wb_i[win_q]) begin
          mem_we_d   = 1'b1;
          mem_addr_d = wb_addr_i[win_q] & ALIGN_MASK;
          state_d    = WB;
        end else begin
          mem_we_d   = 1'b0;
          mem_addr_d = fill_addr_i[win_q] & ALIGN_MASK;
          state_d    = FILL;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          mem_we_d   = 1'b0;
          mem_addr_d = fill_addr_q;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          line_d        = mem_rdata_i;
          mem_req_d     = 1'b0;
          done_d[win_q] = 1'b1;
          state_d       = RESPOND;
        end
      end
      RESPOND: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      fill_addr_q <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      line_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifndef SEGRE_MEM_ARB_DPRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      fill_addr_q <= fill_addr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      line_q      <= line_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef SEGRE_MEM_ARB_DPRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign line_o      = line_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed latency/reset cases, then random two-port traffic against a scoreboard.
module tb_segre_mem_arbiter;
  localparam int AW  = 32;
  localparam int LB  = 16;
  localparam int LW  = LB * 8;
  localparam int NTX = 25;

  logic               clk = 1'b0;
  logic               rsn_i;
  logic [1:0]         req_i, wb_i;
  logic [1:0][AW-1:0] wb_addr_i, fill_addr_i;
  logic [1:0][LW-1:0] wb_line_i;
  logic [1:0]         grant_o, done_o;
  logic [LW-1:0]      line_o, mem_wdata_o, mem_rdata_i;
  logic               mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0]      mem_addr_o;

  always #5 clk = ~clk;

  segre_mem_arbiter #(.ADDR_W(AW), .LINE_BYTES(LB), .NPORTS(2)) dut (
    .clk_i(clk), .rsn_i(rsn_i), .req_i(req_i), .wb_i(wb_i), .wb_addr_i(wb_addr_i),
    .wb_line_i(wb_line_i), .fill_addr_i(fill_addr_i), .grant_o(grant_o), .done_o(done_o),
    .line_o(line_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic          wb;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_line;
    logic [AW-1:0] fill_addr;
  } req_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } beat_t;

  req_t          exp_port[2][$];
  beat_t         beatq[$];
  logic [LW-1:0] refmem[logic [AW-1:0]];
  int            total = 0;
  int            bad = 0;
  bit            drv_en = 0;
  bit            mon_en = 0;
  logic          mon_last;
  int            ndone[2];
  int            issued[2];
  int            idle_cnt[2];

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~(AW'(LB - 1));
  endfunction

  // Memory contents: last written line, else a fixed pattern derived from the address.
  function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
    if (refmem.exists(a)) return refmem[a];
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1357_9BDF};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'(($urandom_range(0, 15) << 4) | $urandom_range(0, 15));
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s got=violation want=none t=%0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    req_i = '0;
    wb_i = '0;
    mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", LW'(grant_o), '0);
    chk("rst_done", LW'(done_o), '0);
    chk("rst_memreq", LW'(mem_req_o), '0);
    chk("rst_line", line_o, '0);
    rsn_i = 1'b1;
  endtask

  // Requesters and memory: everything driven 1 time unit after the rising edge.
  initial begin
    forever begin
      step();
      if (drv_en) begin
        mem_ack_i   = ($urandom_range(0, 2) != 0);
        mem_rdata_i = (mem_req_o && !mem_we_o) ? mem_rd(mem_addr_o) : rnd_line();
        for (int p = 0; p < 2; p++) begin
          if (req_i[p]) begin
            if (done_o[p]) begin
              req_i[p]    = 1'b0;
              idle_cnt[p] = $urandom_range(0, 3);
            end else if (grant_o[p] && mem_req_o) begin
              // Scribble on the request after it was latched; must have no effect.
              wb_i[p]        = $urandom_range(0, 1) != 0;
              wb_addr_i[p]   = rnd_addr();
              wb_line_i[p]   = rnd_line();
              fill_addr_i[p] = rnd_addr();
            end
          end else if (issued[p] < NTX) begin
            if (idle_cnt[p] == 0) begin
              req_t r;
              r.wb = $urandom_range(0, 1) != 0;
              r.wb_addr = rnd_addr();
              r.wb_line = rnd_line();
              r.fill_addr = rnd_addr();
              wb_i[p] = r.wb;
              wb_addr_i[p] = r.wb_addr;
              wb_line_i[p] = r.wb_line;
              fill_addr_i[p] = r.fill_addr;
              exp_port[p].push_back(r);
              req_i[p] = 1'b1;
              issued[p]++;
            end else begin
              idle_cnt[p]--;
            end
          end
        end
      end
    end
  end

  // Monitor: samples 2 time units after the edge, after this cycle's inputs settle.
  initial begin
    logic [1:0]    pg, pr, pd, want_g;
    int            owner, w;
    logic [AW-1:0] exp_fill;
    pg = '0; pr = '0; pd = '0; owner = 0; exp_fill = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (grant_o != 2'b00 && pg == 2'b00) begin
          if (pr == 2'b00) fail("grant_without_req");
          if (pr == 2'b11) begin
`ifdef SEGRE_MEM_ARB_DPRIO_EN
            w = 1;
`else
            w = mon_last ? 0 : 1;
`endif
          end else begin
            w = pr[1] ? 1 : 0;
          end
          want_g = 2'b01 << w;
          chk("grant_winner", LW'(grant_o), LW'(want_g));
          mon_last = w[0];
          owner = w;
          if (exp_port[w].size() == 0) begin
            fail("grant_no_pending");
          end else begin
            req_t r;
            beat_t b;
            r = exp_port[w].pop_front();
            if (r.wb) begin
              b.we = 1'b1; b.addr = align(r.wb_addr); b.data = r.wb_line;
              beatq.push_back(b);
            end
            b.we = 1'b0; b.addr = align(r.fill_addr); b.data = '0;
            beatq.push_back(b);
            exp_fill = align(r.fill_addr);
          end
        end
        if (grant_o == 2'b00 && pg == 2'b00 && pr != 2'b00) fail("grant_latency");
        if (pg != 2'b00 && grant_o != 2'b00) chk("grant_hold", LW'(grant_o), LW'(pg));
        if (pd != 2'b00) chk("grant_after_done", LW'(grant_o), '0);
        if (mem_req_o && grant_o == 2'b00) fail("memreq_without_grant");
        if (mem_req_o && mem_ack_i) begin
          if (beatq.size() == 0) begin
            fail("unexpected_beat");
          end else begin
            beat_t b;
            b = beatq.pop_front();
            chk("beat_we", LW'(mem_we_o), LW'(b.we));
            chk("beat_addr", LW'(mem_addr_o), LW'(b.addr));
            if (b.we) begin
              chk("beat_wdata", mem_wdata_o, b.data);
              refmem[b.addr] = b.data;
            end
          end
        end
        if (done_o != 2'b00) begin
          want_g = 2'b01 << owner;
          chk("done_port", LW'(done_o), LW'(want_g));
          chk("done_beats_left", LW'(beatq.size()), '0);
          chk("done_line", line_o, mem_rd(exp_fill));
          if (pd != 2'b00) fail("done_width");
          ndone[owner]++;
        end
      end
      pg = grant_o;
      pr = req_i;
      pd = done_o;
    end
  end

  initial begin
    logic [LW-1:0] rdat;
    req_i = '0; wb_i = '0; wb_addr_i = '0; wb_line_i = '0; fill_addr_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    ndone[0] = 0; ndone[1] = 0; issued[0] = 0; issued[1] = 0; idle_cnt[0] = 0; idle_cnt[1] = 0;
    rsn_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single icache fill, zero-wait memory: cycle 0 is the IDLE cycle with req high.
    rdat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    req_i = 2'b01; wb_i = 2'b00; fill_addr_i[0] = 32'h0000_1234;
    mem_ack_i = 1'b1; mem_rdata_i = rdat;
    step();
    chk("d1_grant_c1", LW'(grant_o), LW'(2'b01));
    chk("d1_memreq_c1", LW'(mem_req_o), '0);
    step();
    chk("d1_memreq_c2", LW'(mem_req_o), LW'(1'b1));
    chk("d1_we_c2", LW'(mem_we_o), '0);
    chk("d1_addr_c2", LW'(mem_addr_o), LW'(32'h0000_1230));
    step();
    chk("d1_done_c3", LW'(done_o), LW'(2'b01));
    chk("d1_line_c3", line_o, rdat);
    chk("d1_memreq_c3", LW'(mem_req_o), '0);
    req_i = 2'b00;
    step();
    chk("d1_done_c4", LW'(done_o), '0);
    chk("d1_grant_c4", LW'(grant_o), '0);

    // Reset while a dcache fill is stalled.
    step();
    req_i = 2'b10; wb_i = 2'b00; fill_addr_i[1] = 32'h0000_3008; mem_ack_i = 1'b0;
    step();
    chk("d2_grant", LW'(grant_o), LW'(2'b10));
    step();
    chk("d2_fill_addr", LW'(mem_addr_o), LW'(32'h0000_3000));
    step();
    chk("d2_stall_memreq", LW'(mem_req_o), LW'(1'b1));
    rsn_i = 1'b0;
    #1;
    chk("d2_rst_memreq", LW'(mem_req_o), '0);
    chk("d2_rst_grant", LW'(grant_o), '0);
    chk("d2_rst_done", LW'(done_o), '0);
    step();
    rsn_i = 1'b1; req_i = 2'b01; fill_addr_i[0] = 32'h0000_0040; mem_ack_i = 1'b1;
    step();
    chk("d2_regrant", LW'(grant_o), LW'(2'b01));
    step();
    step();
    chk("d2_redone", LW'(done_o), LW'(2'b01));
    req_i = 2'b00;
    step();

    // Random two-port traffic.
    do_reset();
    mon_last = 1'b1;
    drv_en = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 8000 && !(ndone[0] == NTX && ndone[1] == NTX); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    chk("rand_done_port0", LW'(ndone[0]), LW'(NTX));
    chk("rand_done_port1", LW'(ndone[1]), LW'(NTX));
    chk("rand_beats_left", LW'(beatq.size()), '0);
    chk("rand_pending_left", LW'(exp_port[0].size() + exp_port[1].size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Sequences line-granular miss traffic from the instruction cache (port 0) and the data cache (port 1) onto the single shared main-memory port.
- Each request is an optional dirty-line writeback followed by a line fill, executed atomically: no other port is interleaved between the writeback and the fill.
- Sits between both cache controllers and the memory model/bus interface.

Parameters:
ADDR_W, 32, address width in bits
LINE_BYTES, 16, cache line size in bytes (power of two, >=4)
NPORTS, 2, number of requesters; fixed at 2 in this revision (0 = icache, 1 = dcache)

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  asynchronous active-low reset
req_i  in  NPORTS  per-port miss request; held high until that port's done_o
wb_i  in  NPORTS  per-port: writeback required before fill; sampled at grant
wb_addr_i  in  NPORTS x ADDR_W  per-port victim line address
wb_line_i  in  NPORTS x LINE_BYTES x 8  per-port victim line data
fill_addr_i  in  NPORTS x ADDR_W  per-port missing line address
grant_o  out  NPORTS  one-hot; high while the port owns memory (GRANT..RESPOND)
done_o  out  NPORTS  one-cycle pulse; fill line valid on line_o
line_o  out  LINE_BYTES x 8  fill data, shared by both ports, held until the next fill completes
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = line write, 0 = line read
mem_addr_o  out  ADDR_W  line-aligned address; low log2(LINE_BYTES) bits forced to 0
mem_wdata_o  out  LINE_BYTES x 8  write line
mem_ack_i  in  1  memory accepts/completes the current beat
mem_rdata_i  in  LINE_BYTES x 8  read line; valid in the cycle mem_req_o & mem_ack_i & !mem_we_o

Behaviour:
- Reset (async): state IDLE, last-grant pointer = 1 (so port 0 wins first), all outputs 0, line_o = 0. If reset is asserted mid-transaction, mem_req_o drops immediately and the transaction is abandoned; requesters reissue after reset.
- FSM states: IDLE, GRANT, WB, FILL, RESPOND.
- IDLE:
  - If any req_i is high, select a port by round-robin. The port not equal to the last granted port wins on conflict; if only one port requests, it wins. Update the pointer.
  - Go to GRANT. No mem_req_o in IDLE.
- GRANT:
  - Latch the winner's wb_i, wb_addr_i, wb_line_i and fill_addr_i into internal registers. Later input changes are ignored.
  - Next state is WB if the latched wb = 1, else FILL.
- WB:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = latched wb_addr (aligned), mem_wdata_o = latched line.
  - Hold until mem_ack_i, then go to FILL.
- FILL:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched fill_addr (aligned).
  - On mem_ack_i, capture mem_rdata_i into line_o and go to RESPOND.
- RESPOND:
  - done_o[winner] = 1 for exactly this cycle. Go to IDLE.
  - The requester drops req_i in the cycle after done. A req_i still high in IDLE is treated as a new request.
- Request signal and timing:
  - mem_req_o is registered-state-driven and never glitches.
  - mem_ack_i is ignored when mem_req_o = 0.
  - mem_ack_i may arrive in the same cycle mem_req_o first rises, giving zero wait states.
- Latency (zero-wait memory, request in IDLE at cycle 0):
  - grant_o rises at cycle 1 (GRANT).
  - Without writeback: FILL at cycle 2, done_o at cycle 3.
  - With writeback: WB at cycle 2, FILL at cycle 3, done_o at cycle 4.
- grant_o is high for the winner from GRANT through RESPOND inclusive and 0 otherwise.
- A losing requester simply waits; its req_i stays high with no side effects.

Optional Feature:
SEGRE_MEM_ARB_DPRIO_EN
- Defined: fixed priority. Port 1 (dcache) wins any conflict in IDLE and the round-robin pointer is unused. Intended to reduce load-miss latency at the cost of icache starvation risk.
- Undefined: round-robin as specified above.

Test Plan:
- Single icache fill: req_i = 01, wb_i = 0, fill_addr = 0x0000_1234, mem_ack_i always 1.
  -> mem read at 0x0000_1230 in cycle 2; done_o = 01 in cycle 3; line_o = mem_rdata_i of cycle 2.
- dcache dirty miss: req_i = 10, wb_i = 10, wb_addr = 0x0000_2000, fill_addr = 0x0000_3008, ack delayed 3 cycles per beat.
  -> write to 0x2000 with the wb line, then read at 0x3000; mem_req_o held through each stall; done_o = 10 once.
- Simultaneous requests, req_i = 11 from reset, three back-to-back rounds with both ports always requesting.
  -> grant order 0, 1, 0; each done pulse is a single cycle. With SEGRE_MEM_ARB_DPRIO_EN: order 1, 1, 1.
- Input change after grant: port 1 alters fill_addr_i from 0x100 to 0x200 during WB.
  -> FILL address = 0x100.
- Reset mid-FILL: rsn_i low while mem_req_o = 1, ack withheld.
  -> mem_req_o, grant_o and done_o are 0 in the same cycle; after release the FSM is in IDLE and a new req_i = 01 is granted at the next edge after IDLE.
